// File: rtl/mult_bist_pkg.sv
// Shared types and pattern tables for the multiplier pattern BIST.
// Window periods, b-operand byte patterns and the controller state encoding.
package mult_bist_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } bist_state_e;

   localparam int PER_LO [16] = '{1, 1, 1, 1, 1, 1, 2, 2, 2, 2, 2, 4, 4, 4, 4, 4};
   localparam int PER_HI [16] = '{4, 4, 4, 4, 8, 8, 8, 8, 12, 12, 12, 12, 16, 16, 16, 16};

   // Every period used by either window; each gets one shared mod-p counter.
   localparam int NUM_PER = 6;
   localparam int DIST_PER [NUM_PER] = '{1, 2, 4, 8, 12, 16};

   localparam logic [7:0] B_PAT [4] = '{8'hAA, 8'h55, 8'hFF, 8'h0F};

   function automatic int per_index(input int p);
      for (int i = 0; i < NUM_PER; i++) begin
         if (DIST_PER[i] == p) return i;
      end
      return 0;
   endfunction

endpackage

// File: rtl/sig_misr.sv
// Response compactor: XOR-folds a wide input to MISR_W bits and clocks it
// into a multiple-input signature register.
module sig_misr #(
   parameter int                MISR_W = 32,
   parameter logic [MISR_W-1:0] POLY   = 32'h04C11DB7,
   parameter logic [MISR_W-1:0] SEED   = 32'hFFFFFFFF,
   parameter int                DIN_W  = 128
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              en,
   input  logic [DIN_W-1:0]  din,
   output logic [MISR_W-1:0] sig
);

   logic [MISR_W-1:0] fold;

   always_comb begin
      fold = '0;
      for (int m = 0; m < DIN_W / MISR_W; m++) begin
         fold = fold ^ din[m*MISR_W +: MISR_W];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig <= SEED;
      end else if (clr) begin
         sig <= SEED;
      end else if (en) begin
         sig <= {sig[MISR_W-2:0], 1'b0} ^ (sig[MISR_W-1] ? POLY : '0) ^ fold;
      end
   end

endmodule

// File: rtl/mult_pattern_bist.sv
// Three-phase multi-frequency stimulus generator for multiplier netlists,
// sampling the product into a MISR signature once per vector.
module mult_pattern_bist
   import mult_bist_pkg::*;
#(
   parameter int                A_W       = 64,
   parameter int                B_W       = 64,
   parameter int                F_W       = 128,
   parameter int                WIN_W     = 16,
   parameter int                HI_BASE   = A_W - WIN_W,
   parameter int                STEPS     = 256,
   parameter int                PHASE_LEN = 48,
   parameter int                SEG_LEN   = 64,
   parameter int                SETTLE    = 1,
   parameter int                MISR_W    = 32,
   parameter logic [MISR_W-1:0] MISR_POLY = 32'h04C11DB7,
   parameter logic [MISR_W-1:0] MISR_SEED = 32'hFFFFFFFF
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic                       abort,
   output logic                       busy,
   output logic                       done,
   output logic [A_W-1:0]             a_vec,
   output logic [B_W-1:0]             b_vec,
   input  logic [F_W-1:0]             f_vec,
   output logic [$clog2(STEPS+1)-1:0] step,
   output logic [27:0]                obs,
   output logic [MISR_W-1:0]          signature
);

   localparam int SW = $clog2(STEPS + 1);
   localparam int HW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
   localparam int GW = (SEG_LEN > 1) ? $clog2(SEG_LEN) : 1;
   localparam int CW = 5;

   bist_state_e state, state_nxt;
   logic load, adv, sample, finish, clear;
   logic last_hold, last_step;

   logic [HW-1:0] hold_cnt;
   logic [GW-1:0] seg_cnt, seg_cnt_adv;
   logic [1:0]    seg_idx, seg_idx_adv;
   logic [CW-1:0] per_cnt [NUM_PER];
   logic [CW-1:0] per_cnt_adv [NUM_PER];
   logic          per_q [NUM_PER];
   logic          per_q_adv [NUM_PER];
   logic [SW-1:0] step_adv;
   logic [A_W-1:0] a_adv;
   logic [B_W-1:0] b_adv;

   function automatic logic win_bit(input logic [SW-1:0] s, input logic q, input int k);
      if (int'(s) < PHASE_LEN) return 1'b0;
      if (int'(s) < 2 * PHASE_LEN) return 1'b1;
      return q ^ k[0];
   endfunction

   assign last_hold = (hold_cnt == HW'(SETTLE));
   assign last_step = (step == SW'(STEPS - 1));
   assign busy      = (state == ST_RUN);
   assign done      = (state == ST_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      adv       = 1'b0;
      sample    = 1'b0;
      finish    = 1'b0;
      clear     = abort;
      if (abort) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state_nxt = ST_RUN;
                  load      = 1'b1;
               end
            end
            ST_RUN: begin
               if (last_hold) begin
                  sample = 1'b1;
                  if (last_step) begin
                     finish    = 1'b1;
                     state_nxt = ST_DONE;
                  end else begin
                     adv = 1'b1;
                  end
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   // Counters track step mod p and parity of step/p, so window bits need no divider.
   always_comb begin
      step_adv = step + 1'b1;
      for (int i = 0; i < NUM_PER; i++) begin
         if (per_cnt[i] == CW'(DIST_PER[i] - 1)) begin
            per_cnt_adv[i] = '0;
            per_q_adv[i]   = ~per_q[i];
         end else begin
            per_cnt_adv[i] = per_cnt[i] + 1'b1;
            per_q_adv[i]   = per_q[i];
         end
      end
      if (seg_cnt == GW'(SEG_LEN - 1)) begin
         seg_cnt_adv = '0;
         seg_idx_adv = seg_idx + 1'b1;
      end else begin
         seg_cnt_adv = seg_cnt + 1'b1;
         seg_idx_adv = seg_idx;
      end
      a_adv = '0;
      for (int k = 0; k < WIN_W; k++) begin
         a_adv[k]           = win_bit(step_adv, per_q_adv[per_index(PER_LO[k])], k);
         a_adv[HI_BASE + k] = win_bit(step_adv, per_q_adv[per_index(PER_HI[k])], k);
      end
      b_adv      = '0;
      b_adv[7:0] = B_PAT[seg_idx_adv];
   end

   // Vector 0 always falls in the all-zero phase, so a start loads a_vec with zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_vec    <= '0;
         b_vec    <= '0;
         step     <= '0;
         hold_cnt <= '0;
         seg_cnt  <= '0;
         seg_idx  <= '0;
         for (int i = 0; i < NUM_PER; i++) begin
            per_cnt[i] <= '0;
            per_q[i]   <= 1'b0;
         end
      end else if (clear || load) begin
         a_vec    <= '0;
         b_vec    <= clear ? '0 : B_W'(B_PAT[0]);
         step     <= '0;
         hold_cnt <= '0;
         seg_cnt  <= '0;
         seg_idx  <= '0;
         for (int i = 0; i < NUM_PER; i++) begin
            per_cnt[i] <= '0;
            per_q[i]   <= 1'b0;
         end
      end else if (adv) begin
         a_vec    <= a_adv;
         b_vec    <= b_adv;
         step     <= step_adv;
         hold_cnt <= '0;
         seg_cnt  <= seg_cnt_adv;
         seg_idx  <= seg_idx_adv;
         for (int i = 0; i < NUM_PER; i++) begin
            per_cnt[i] <= per_cnt_adv[i];
            per_q[i]   <= per_q_adv[i];
         end
      end else if (finish) begin
         a_vec    <= '0;
         b_vec    <= '0;
         hold_cnt <= '0;
      end else if (state == ST_RUN) begin
         hold_cnt <= hold_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) obs <= '0;
      else if (sample) obs <= {f_vec[F_W-1 -: 16], f_vec[67:64], f_vec[35:32], f_vec[3:0]};
   end

   sig_misr #(
      .MISR_W (MISR_W),
      .POLY   (MISR_POLY),
      .SEED   (MISR_SEED),
      .DIN_W  (F_W)
   ) u_misr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clear || load),
      .en    (sample),
      .din   (f_vec),
      .sig   (signature)
   );

endmodule

// File: tb/tb_mult_pattern_bist.sv
// Directed bench for mult_pattern_bist: default instance plus a short
// SETTLE=3 / STEPS=16 instance, both driving an a*b product back in.
module tb_mult_pattern_bist;

   localparam logic [31:0] POLY = 32'h04C11DB7;
   localparam logic [31:0] SEED = 32'hFFFFFFFF;
   localparam int PLO [16] = '{1, 1, 1, 1, 1, 1, 2, 2, 2, 2, 2, 4, 4, 4, 4, 4};
   localparam int PHI [16] = '{4, 4, 4, 4, 8, 8, 8, 8, 12, 12, 12, 12, 16, 16, 16, 16};
   localparam logic [7:0] BP [4] = '{8'hAA, 8'h55, 8'hFF, 8'h0F};

   logic clk = 1'b0;
   logic rst_n, start, abort, start1, stuck;

   logic         busy, done;
   logic [63:0]  a_vec, b_vec;
   logic [127:0] f_vec;
   logic [8:0]   step;
   logic [27:0]  obs;
   logic [31:0]  signature;

   logic         busy1, done1;
   logic [63:0]  a1, b1;
   logic [127:0] f1;
   logic [4:0]   step1;
   logic [27:0]  obs1;
   logic [31:0]  sig1;

   int checks = 0;
   int passes = 0;
   int cyc = 0;
   logic [31:0] good_sig;
   logic [31:0] sig_run1;

   assign f_vec = ({64'd0, a_vec} * {64'd0, b_vec}) | {63'd0, stuck, 64'd0};
   assign f1    = {64'd0, a1} * {64'd0, b1};

   always #5 clk = ~clk;

   mult_pattern_bist u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .busy(busy), .done(done), .a_vec(a_vec), .b_vec(b_vec), .f_vec(f_vec),
      .step(step), .obs(obs), .signature(signature)
   );

   mult_pattern_bist #(.STEPS(16), .SETTLE(3)) u_short (
      .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0),
      .busy(busy1), .done(done1), .a_vec(a1), .b_vec(b1), .f_vec(f1),
      .step(step1), .obs(obs1), .signature(sig1)
   );

   function automatic logic [63:0] exp_a(input int s);
      logic [63:0] a = '0;
      for (int k = 0; k < 16; k++) begin
         if (s < 48) begin
            a[k] = 1'b0; a[48+k] = 1'b0;
         end else if (s < 96) begin
            a[k] = 1'b1; a[48+k] = 1'b1;
         end else begin
            a[k]    = (((s / PLO[k]) + k) % 2) == 1;
            a[48+k] = (((s / PHI[k]) + k) % 2) == 1;
         end
      end
      return a;
   endfunction

   function automatic logic [63:0] exp_b(input int s);
      return {56'd0, BP[(s / 64) % 4]};
   endfunction

   function automatic logic [127:0] exp_f(input int s);
      return {64'd0, exp_a(s)} * {64'd0, exp_b(s)};
   endfunction

   function automatic logic [27:0] exp_obs(input int s);
      logic [127:0] f = exp_f(s);
      return {f[127:112], f[67:64], f[35:32], f[3:0]};
   endfunction

   function automatic logic [31:0] model_sig(input int steps, input bit stuck64);
      logic [31:0]  sig = SEED;
      logic [127:0] f;
      logic [31:0]  fold;
      for (int s = 0; s < steps; s++) begin
         f = exp_f(s);
         if (stuck64) f[64] = 1'b1;
         fold = f[31:0] ^ f[63:32] ^ f[95:64] ^ f[127:96];
         sig  = {sig[30:0], 1'b0} ^ (sig[31] ? POLY : 32'd0) ^ fold;
      end
      return sig;
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic advanceTo(input int c);
      while (cyc < c) tick(1);
   endtask

   task automatic applyStimulus(input logic s, input logic ab, input logic s1);
      start  = s;
      abort  = ab;
      start1 = s1;
      tick(1);
      start  = 1'b0;
      abort  = 1'b0;
      start1 = 1'b0;
      cyc    = 0;
   endtask

   task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      assert (got === exp) passes++;
      else $error("[TB] FAIL %s: observed %h, expected %h", tag, got, exp);
   endtask

   initial begin
      rst_n  = 1'b0;
      start  = 1'b0;
      abort  = 1'b0;
      start1 = 1'b0;
      stuck  = 1'b0;
      tick(2);
      checkOutput("rst_busy", 128'(busy), 128'(0));
      checkOutput("rst_done", 128'(done), 128'(0));
      checkOutput("rst_a", 128'(a_vec), 128'(0));
      checkOutput("rst_b", 128'(b_vec), 128'(0));
      checkOutput("rst_sig", 128'(signature), 128'(SEED));
      rst_n = 1'b1;
      tick(1);

      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("s0_busy", 128'(busy), 128'(1));
      checkOutput("s0_step", 128'(step), 128'(0));
      checkOutput("s0_a", 128'(a_vec), 128'(0));
      checkOutput("s0_b", 128'(b_vec), 128'(64'hAA));
      tick(1);
      checkOutput("s0_hold", 128'(step), 128'(0));
      tick(1);
      checkOutput("s1_step", 128'(step), 128'(1));
      advanceTo(80);
      checkOutput("s40_step", 128'(step), 128'(40));

      rst_n = 1'b0;
      tick(1);
      checkOutput("midrst_busy", 128'(busy), 128'(0));
      checkOutput("midrst_done", 128'(done), 128'(0));
      checkOutput("midrst_step", 128'(step), 128'(0));
      checkOutput("midrst_b", 128'(b_vec), 128'(0));
      checkOutput("midrst_obs", 128'(obs), 128'(0));
      checkOutput("midrst_sig", 128'(signature), 128'(SEED));
      rst_n = 1'b1;
      tick(1);

      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("restart_step", 128'(step), 128'(0));
      checkOutput("restart_busy", 128'(busy), 128'(1));
      advanceTo(100);
      checkOutput("s50_a", 128'(a_vec), 128'(64'hFFFF_0000_0000_FFFF));
      advanceTo(128);
      checkOutput("s64_b", 128'(b_vec), 128'(64'h55));
      advanceTo(192);
      checkOutput("s96_a", 128'(a_vec), 128'(64'hAAAA_0000_0000_AAAA));
      advanceTo(194);
      checkOutput("s96_obs", 128'(obs), 128'(exp_obs(96)));
      advanceTo(256);
      checkOutput("s128_b", 128'(b_vec), 128'(64'hFF));
      advanceTo(384);
      checkOutput("s192_b", 128'(b_vec), 128'(64'h0F));
      advanceTo(511);
      checkOutput("pre_done", 128'(done), 128'(0));
      while (done !== 1'b1 && cyc < 700) tick(1);
      checkOutput("done_cycle", 128'(cyc), 128'(512));
      checkOutput("done_busy", 128'(busy), 128'(0));
      checkOutput("done_a", 128'(a_vec), 128'(0));
      checkOutput("done_b", 128'(b_vec), 128'(0));
      checkOutput("done_obs", 128'(obs), 128'(exp_obs(255)));
      good_sig = model_sig(256, 1'b0);
      checkOutput("golden_sig", 128'(signature), 128'(good_sig));

      stuck = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b0);
      while (done !== 1'b1 && cyc < 700) tick(1);
      checkOutput("fault_done_cycle", 128'(cyc), 128'(512));
      checkOutput("fault_sig", 128'(signature), 128'(model_sig(256, 1'b1)));
      checkOutput("fault_sig_differs", 128'(signature != good_sig), 128'(1));
      stuck = 1'b0;

      applyStimulus(1'b1, 1'b0, 1'b0);
      advanceTo(200);
      checkOutput("s100_step", 128'(step), 128'(100));
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("abort_busy", 128'(busy), 128'(0));
      checkOutput("abort_done", 128'(done), 128'(0));
      checkOutput("abort_a", 128'(a_vec), 128'(0));
      checkOutput("abort_sig", 128'(signature), 128'(SEED));
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("startabort_busy", 128'(busy), 128'(0));
      checkOutput("startabort_done", 128'(done), 128'(0));
      tick(3);
      checkOutput("startabort_idle", 128'(busy), 128'(0));

      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("short_s0_b", 128'(b1), 128'(64'hAA));
      advanceTo(3);
      checkOutput("short_hold3", 128'(step1), 128'(0));
      advanceTo(4);
      checkOutput("short_step1", 128'(step1), 128'(1));
      while (done1 !== 1'b1 && cyc < 200) tick(1);
      checkOutput("short_done_cycle", 128'(cyc), 128'(64));
      checkOutput("short_sig", 128'(sig1), 128'(model_sig(16, 1'b0)));
      sig_run1 = sig1;
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("short_rerun_busy", 128'(busy1), 128'(1));
      while (done1 !== 1'b1 && cyc < 200) tick(1);
      checkOutput("short_rerun_cycle", 128'(cyc), 128'(64));
      checkOutput("short_rerun_sig", 128'(sig1), 128'(sig_run1));

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
